// File: rtl/axi_ar_pkg.sv
// Shared definitions for the AXI read-address issue path: FSM states,
// AXI burst constants and the layout of a queued read request.
package axi_ar_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        ISSUE = 2'd2
    } arState_e;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam int         PAGE_BYTES    = 4096;
    localparam int         PAGE_OFFSET_W = 12;

    // A FIFO entry is {len[7:0], addr}; the length field sits directly above the address.
    localparam int ENTRY_ADDR_LSB = 0;
    localparam int ENTRY_LEN_W    = 8;

    function automatic int entryLenLsb(input int addrWidth);
        return ENTRY_ADDR_LSB + addrWidth;
    endfunction

endpackage

// File: rtl/axi_outstanding_cnt.sv
// In-flight read burst counter: counts AR handshakes up and final R beats down,
// saturating at 0 and at the configured limit, and reports headroom now and next cycle.
module axi_outstanding_cnt
    import axi_ar_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       inc_i,
    input  logic       dec_i,
    output logic [7:0] count_o,
    output logic       belowLimit_o,
    output logic       belowLimitNext_o
);

    localparam logic [7:0] LIMIT = 8'(MAX_OUTSTANDING);

    logic [7:0] count_q;
    logic [7:0] count_d;
    logic       decOk;

    // A last beat with nothing in flight is a slave protocol error and is dropped.
    always_comb begin
        count_d = count_q;
        decOk   = dec_i && (count_q != 8'd0);
        if (inc_i && !decOk) begin
            if (count_q < LIMIT) begin
                count_d = count_q + 8'd1;
            end
        end else if (decOk && !inc_i) begin
            count_d = count_q - 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 8'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o          = count_q;
    assign belowLimit_o     = (count_q < LIMIT);
    assign belowLimitNext_o = (count_d < LIMIT);

endmodule

// File: rtl/axi_ar_issue.sv
// Drains queued read requests from the araddr FIFO onto the AXI4 AR channel,
// throttling on in-flight bursts and flagging bursts that cross a 4 KB page.
module axi_ar_issue
    import axi_ar_pkg::*;
#(
    parameter int ADDR_WIDTH      = 32,
    parameter int ID_WIDTH        = 4,
    parameter int AXI_ID          = 0,
    parameter int BYTES_LOG2      = 3,
    parameter int MAX_OUTSTANDING = 8,
    parameter int FIFO_DATA_WIDTH = ADDR_WIDTH + 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [FIFO_DATA_WIDTH-1:0] fifo_rd_data,
    input  logic                       fifo_rd_empty,
    output logic                       fifo_rd_en,
    output logic [ID_WIDTH-1:0]        m_axi_arid,
    output logic [ADDR_WIDTH-1:0]      m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic                       m_axi_rvalid,
    input  logic                       m_axi_rready,
    input  logic                       m_axi_rlast,
    output logic [7:0]                 outstanding,
    output logic                       boundary_err,
    output logic                       busy
);

    localparam int LEN_LSB = entryLenLsb(ADDR_WIDTH);
    localparam int EW      = ADDR_WIDTH + 1;

    arState_e                 state_q;
    logic [ADDR_WIDTH-1:0]    arAddr_q;
    logic [7:0]               arLen_q;
    logic                     arValid_q;
    logic                     boundErr_q;

    logic [ADDR_WIDTH-1:0]    entryAddr;
    logic [ENTRY_LEN_W-1:0]   entryLen;
    logic [EW-1:0]            burstEnd;
    logic                     crossesPage;
    logic                     arHandshake;
    logic                     rLastBeat;
    logic                     popNow;
    logic                     belowLimit;
    logic                     belowLimitNext;
    logic [7:0]               count;

    assign entryAddr   = fifo_rd_data[ENTRY_ADDR_LSB +: ADDR_WIDTH];
    assign entryLen    = fifo_rd_data[LEN_LSB +: ENTRY_LEN_W];
    assign burstEnd    = EW'(entryAddr[PAGE_OFFSET_W-1:0])
                       + ((EW'(entryLen) + EW'(1)) << BYTES_LOG2);
    assign crossesPage = (burstEnd > EW'(PAGE_BYTES));

    assign arHandshake = arValid_q && m_axi_arready;
    assign rLastBeat   = m_axi_rvalid && m_axi_rready && m_axi_rlast;

    axi_outstanding_cnt #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_outstandingCnt (
        .clk              (clk),
        .rst_n            (rst_n),
        .inc_i            (arHandshake),
        .dec_i            (rLastBeat),
        .count_o          (count),
        .belowLimit_o     (belowLimit),
        .belowLimitNext_o (belowLimitNext)
    );

    // The pop is combinational so FIFO data lands in LOAD; on a handshake the
    // just-issued burst is already counted, so the post-update count decides.
    always_comb begin
        popNow = 1'b0;
        case (state_q)
            IDLE:    popNow = !fifo_rd_empty && belowLimit;
            ISSUE:   popNow = arHandshake && !fifo_rd_empty && belowLimitNext;
            default: popNow = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            arAddr_q   <= '0;
            arLen_q    <= 8'd0;
            arValid_q  <= 1'b0;
            boundErr_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (popNow) begin
                        state_q <= LOAD;
                    end
                end
                LOAD: begin
                    arAddr_q  <= entryAddr;
                    arLen_q   <= entryLen;
                    arValid_q <= 1'b1;
                    if (crossesPage) begin
                        boundErr_q <= 1'b1;
                    end
                    state_q   <= ISSUE;
                end
                ISSUE: begin
                    // Valid drops even when chaining, otherwise LOAD would replay the old request.
                    if (arHandshake) begin
                        arValid_q <= 1'b0;
                        state_q   <= popNow ? LOAD : IDLE;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    arValid_q <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_rd_en    = popNow && rst_n;
    assign m_axi_arid    = ID_WIDTH'(AXI_ID);
    assign m_axi_araddr  = arAddr_q;
    assign m_axi_arlen   = arLen_q;
    assign m_axi_arsize  = 3'(BYTES_LOG2);
    assign m_axi_arburst = BURST_INCR;
    assign m_axi_arvalid = arValid_q;
    assign outstanding   = count;
    assign boundary_err  = boundErr_q;
    assign busy          = (state_q != IDLE) || (count != 8'd0);

endmodule

// File: tb/tb_axi_ar_issue.sv
// Self-checking bench for axi_ar_issue: a FIFO and R-channel slave model drive
// the DUT while a negedge monitor scores AR requests and burst counts.
module tb_axi_ar_issue;

    localparam int AW       = 32;
    localparam int IDW      = 4;
    localparam int AXI_ID_P = 5;
    localparam int BL2      = 3;
    localparam int MAXO     = 4;
    localparam int FW       = AW + 8;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } arReq_t;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [FW-1:0]  fifo_rd_data;
    logic           fifo_rd_empty;
    logic           fifo_rd_en;
    logic [IDW-1:0] m_axi_arid;
    logic [AW-1:0]  m_axi_araddr;
    logic [7:0]     m_axi_arlen;
    logic [2:0]     m_axi_arsize;
    logic [1:0]     m_axi_arburst;
    logic           m_axi_arvalid;
    logic           m_axi_arready;
    logic           m_axi_rvalid;
    logic           m_axi_rready;
    logic           m_axi_rlast;
    logic [7:0]     outstanding;
    logic           boundary_err;
    logic           busy;

    int checks = 0;
    int errors = 0;

    logic [FW-1:0] fifoQ[$];
    arReq_t        expQ[$];
    int            rQ[$];
    int            hsCycles[$];
    int            beatCnt = 0;
    int            rMode = 0;
    int            arReadyMode = 0;
    int            modelCnt = 0;
    int            cycle = 0;
    int            hsTotal = 0;
    bit            refErr = 0;
    bit            popSeen = 0;
    bit            rBeatSeen = 0;
    bit            stallValid = 0;
    logic [AW-1:0] stallAddr;
    logic [7:0]    stallLen;

    always #5 clk = ~clk;

    axi_ar_issue #(
        .ADDR_WIDTH      (AW),
        .ID_WIDTH        (IDW),
        .AXI_ID          (AXI_ID_P),
        .BYTES_LOG2      (BL2),
        .MAX_OUTSTANDING (MAXO),
        .FIFO_DATA_WIDTH (FW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .fifo_rd_data  (fifo_rd_data),
        .fifo_rd_empty (fifo_rd_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axi_arid    (m_axi_arid),
        .m_axi_araddr  (m_axi_araddr),
        .m_axi_arlen   (m_axi_arlen),
        .m_axi_arsize  (m_axi_arsize),
        .m_axi_arburst (m_axi_arburst),
        .m_axi_arvalid (m_axi_arvalid),
        .m_axi_arready (m_axi_arready),
        .m_axi_rvalid  (m_axi_rvalid),
        .m_axi_rready  (m_axi_rready),
        .m_axi_rlast   (m_axi_rlast),
        .outstanding   (outstanding),
        .boundary_err  (boundary_err),
        .busy          (busy)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic bit crossesPage(input logic [AW-1:0] addr, input int len);
        int endByte;
        endByte = int'(addr[11:0]) + (len + 1) * (1 << BL2);
        return endByte > 4096;
    endfunction

    task automatic applyStimulus(input int len, input logic [AW-1:0] addr);
        arReq_t r;
        r.addr = addr;
        r.len  = 8'(len);
        fifoQ.push_back({8'(len), addr});
        expQ.push_back(r);
        fifo_rd_empty = 1'b0;
    endtask

    // Advance one cycle, then act as FIFO read port and R-channel slave.
    task automatic tick();
        @(posedge clk);
        #1;
        if (popSeen && fifoQ.size() > 0) begin
            fifo_rd_data = fifoQ.pop_front();
        end
        popSeen = 0;
        fifo_rd_empty = (fifoQ.size() == 0);
        if (rBeatSeen && rQ.size() > 0) begin
            if (beatCnt == rQ[0]) begin
                void'(rQ.pop_front());
                beatCnt = 0;
            end else begin
                beatCnt++;
            end
        end
        rBeatSeen = 0;
        if (rMode == 0) begin
            m_axi_rvalid = 1'b0;
            m_axi_rready = 1'b0;
            m_axi_rlast  = 1'b0;
        end else if (rMode == 1) begin
            m_axi_rvalid = (rQ.size() > 0) && ($urandom_range(0, 3) != 0);
            m_axi_rlast  = m_axi_rvalid && (beatCnt == rQ[0]);
            m_axi_rready = ($urandom_range(0, 3) != 0);
        end
        if (arReadyMode == 2) begin
            m_axi_arready = ($urandom_range(0, 9) < 7);
        end
    endtask

    task automatic waitDrain(input string name);
        for (int i = 0; i < 5000; i++) begin
            if (fifoQ.size() == 0 && expQ.size() == 0 && rQ.size() == 0 &&
                outstanding == 8'd0 && !busy) break;
            tick();
        end
        checkOutput({name, " pending ARs"}, expQ.size(), 0);
        checkOutput({name, " busy"}, busy, 0);
    endtask

    // Scoreboard monitor: pops an expected request on every AR handshake and
    // tracks the in-flight count from observed AR and final-R handshakes.
    always @(negedge clk) begin
        bit     arHs;
        bit     lastBeat;
        arReq_t e;
        cycle++;
        if (!rst_n) begin
            modelCnt   = 0;
            refErr     = 0;
            stallValid = 0;
            popSeen    = 0;
            rBeatSeen  = 0;
        end else begin
            arHs      = m_axi_arvalid && m_axi_arready;
            lastBeat  = m_axi_rvalid && m_axi_rready && m_axi_rlast;
            popSeen   = fifo_rd_en;
            rBeatSeen = m_axi_rvalid && m_axi_rready;
            checkOutput("outstanding", outstanding, modelCnt);
            if (modelCnt != 0) checkOutput("busy with bursts in flight", busy, 1);
            if (fifo_rd_en) checkOutput("pop while empty", fifo_rd_empty, 0);
            if (m_axi_arvalid && !m_axi_arready) checkOutput("pop during AR stall", fifo_rd_en, 0);
            if (stallValid) begin
                checkOutput("arvalid held", m_axi_arvalid, 1);
                checkOutput("araddr held", m_axi_araddr, stallAddr);
                checkOutput("arlen held", m_axi_arlen, stallLen);
            end
            if (arHs) begin
                checks++;
                if (expQ.size() == 0) begin
                    errors++;
                    $display("[TB] FAIL unexpected AR: got araddr 0x%0h expected no request", m_axi_araddr);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("araddr", m_axi_araddr, e.addr);
                    checkOutput("arlen", m_axi_arlen, e.len);
                    checkOutput("arid", m_axi_arid, AXI_ID_P);
                    checkOutput("arsize", m_axi_arsize, BL2);
                    checkOutput("arburst", m_axi_arburst, 2'b01);
                    refErr = refErr | crossesPage(e.addr, int'(e.len));
                    checkOutput("boundary_err", boundary_err, refErr);
                    rQ.push_back(int'(m_axi_arlen));
                end
                hsTotal++;
                hsCycles.push_back(cycle);
            end
            stallValid = m_axi_arvalid && !m_axi_arready;
            stallAddr  = m_axi_araddr;
            stallLen   = m_axi_arlen;
            modelCnt   = modelCnt + (arHs ? 1 : 0) - ((lastBeat && modelCnt > 0) ? 1 : 0);
            if (modelCnt > MAXO) begin
                errors++;
                $display("[TB] FAIL in-flight limit: got %0d expected at most %0d", modelCnt, MAXO);
                modelCnt = MAXO;
            end
        end
    end

    initial begin
        #900000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        int n;
        int pushed;
        fifo_rd_data  = '0;
        fifo_rd_empty = 1'b1;
        m_axi_arready = 1'b0;
        m_axi_rvalid  = 1'b0;
        m_axi_rready  = 1'b0;
        m_axi_rlast   = 1'b0;
        rst_n         = 1'b0;

        // Reset values, with a non-empty FIFO to prove the pop is held off.
        #23;
        fifo_rd_empty = 1'b0;
        #1;
        checkOutput("reset fifo_rd_en", fifo_rd_en, 0);
        checkOutput("reset arvalid", m_axi_arvalid, 0);
        checkOutput("reset araddr", m_axi_araddr, 0);
        checkOutput("reset arlen", m_axi_arlen, 0);
        checkOutput("reset arsize", m_axi_arsize, BL2);
        checkOutput("reset arburst", m_axi_arburst, 2'b01);
        checkOutput("reset arid", m_axi_arid, AXI_ID_P);
        checkOutput("reset outstanding", outstanding, 0);
        checkOutput("reset boundary_err", boundary_err, 0);
        checkOutput("reset busy", busy, 0);
        fifo_rd_empty = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;

        // Single request: pop, LOAD, then arvalid two cycles after non-empty.
        m_axi_arready = 1'b1;
        tick();
        applyStimulus(15, 32'h0000_1000);
        @(negedge clk);
        checkOutput("latency pop", fifo_rd_en, 1);
        tick();
        @(negedge clk);
        checkOutput("latency load arvalid", m_axi_arvalid, 0);
        checkOutput("latency load pop", fifo_rd_en, 0);
        tick();
        @(negedge clk);
        checkOutput("latency arvalid", m_axi_arvalid, 1);
        checkOutput("latency araddr", m_axi_araddr, 32'h0000_1000);
        checkOutput("latency arlen", m_axi_arlen, 15);
        tick();
        @(negedge clk);
        checkOutput("latency outstanding", outstanding, 1);
        rMode = 1;
        waitDrain("latency drain");

        // A burst ending exactly on the page edge is legal.
        tick();
        applyStimulus(15, 32'h0000_0F80);
        waitDrain("exact page drain");
        checkOutput("boundary exact 4KB", boundary_err, 0);

        // AR stall: fields stable, no further pops, then back-to-back issue.
        m_axi_arready = 1'b0;
        tick();
        for (int i = 0; i < 4; i++) applyStimulus(3, 32'h0000_3000 + 32'(i * 64));
        for (int i = 0; i < 20 && !m_axi_arvalid; i++) tick();
        checkOutput("stall arvalid raised", m_axi_arvalid, 1);
        repeat (5) tick();
        checkOutput("stall fifo depth", fifoQ.size(), 3);
        base = hsTotal;
        m_axi_arready = 1'b1;
        for (int i = 0; i < 40 && hsTotal < base + 4; i++) tick();
        checkOutput("stall AR count", hsTotal - base, 4);
        n = hsCycles.size();
        if (n >= 4) begin
            for (int k = n - 3; k < n; k++) checkOutput("stall AR spacing", hsCycles[k] - hsCycles[k-1], 2);
        end
        waitDrain("stall drain");

        // Throttle at the limit with no R traffic, then one last beat frees a slot.
        rMode = 0;
        tick();
        base = hsTotal;
        for (int i = 0; i < 6; i++) applyStimulus(0, 32'h0000_5000 + 32'(i * 8));
        for (int i = 0; i < 40 && hsTotal < base + 4; i++) tick();
        repeat (10) tick();
        checkOutput("throttle AR count", hsTotal - base, 4);
        checkOutput("throttle outstanding", outstanding, MAXO);
        checkOutput("throttle fifo depth", fifoQ.size(), 2);
        @(negedge clk);
        checkOutput("throttle no pop", fifo_rd_en, 0);
        tick();
        rMode = 2;
        m_axi_rvalid = 1'b1;
        m_axi_rready = 1'b1;
        m_axi_rlast  = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rready = 1'b0;
        m_axi_rlast  = 1'b0;
        rMode = 0;
        for (int i = 0; i < 20 && hsTotal < base + 5; i++) tick();
        repeat (3) tick();
        checkOutput("throttle refill count", hsTotal - base, 5);
        checkOutput("throttle refill outstanding", outstanding, MAXO);
        rMode = 1;
        waitDrain("throttle drain");

        // AR handshake and a final R beat in the same cycle leave the count alone.
        rMode = 0;
        tick();
        for (int i = 0; i < 3; i++) applyStimulus(0, 32'h0000_6000 + 32'(i * 8));
        for (int i = 0; i < 30 && outstanding != 8'd3; i++) tick();
        checkOutput("same-cycle setup", outstanding, 3);
        m_axi_arready = 1'b0;
        applyStimulus(0, 32'h0000_6100);
        for (int i = 0; i < 20 && !m_axi_arvalid; i++) tick();
        checkOutput("same-cycle arvalid", m_axi_arvalid, 1);
        rMode = 2;
        m_axi_arready = 1'b1;
        m_axi_rvalid  = 1'b1;
        m_axi_rready  = 1'b1;
        m_axi_rlast   = 1'b1;
        tick();
        m_axi_rvalid = 1'b0;
        m_axi_rready = 1'b0;
        m_axi_rlast  = 1'b0;
        rMode = 0;
        @(negedge clk);
        checkOutput("same-cycle outstanding", outstanding, 3);
        rMode = 1;
        waitDrain("same-cycle drain");

        // Page crossing sets the sticky flag; a later clean burst keeps it set.
        tick();
        applyStimulus(15, 32'h0000_0FC0);
        waitDrain("crossing drain");
        checkOutput("boundary crossing", boundary_err, 1);
        applyStimulus(7, 32'h0000_2000);
        waitDrain("sticky drain");
        checkOutput("boundary sticky", boundary_err, 1);

        // Asynchronous reset while an AR is waiting for arready.
        rMode = 0;
        tick();
        applyStimulus(0, 32'h0000_7000);
        applyStimulus(0, 32'h0000_7008);
        for (int i = 0; i < 30 && outstanding != 8'd2; i++) tick();
        checkOutput("reset-test setup", outstanding, 2);
        m_axi_arready = 1'b0;
        applyStimulus(1, 32'h0000_7100);
        applyStimulus(1, 32'h0000_7200);
        for (int i = 0; i < 20 && !m_axi_arvalid; i++) tick();
        checkOutput("reset-test arvalid", m_axi_arvalid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async reset arvalid", m_axi_arvalid, 0);
        checkOutput("async reset fifo_rd_en", fifo_rd_en, 0);
        checkOutput("async reset outstanding", outstanding, 0);
        checkOutput("async reset busy", busy, 0);
        checkOutput("async reset boundary_err", boundary_err, 0);
        fifoQ.delete();
        expQ.delete();
        rQ.delete();
        beatCnt = 0;
        fifo_rd_empty = 1'b1;
        m_axi_arready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        rMode = 1;
        base = hsTotal;
        tick();
        applyStimulus(4, 32'h0000_8000);
        waitDrain("resume drain");
        checkOutput("resume AR count", hsTotal - base, 1);

        // Randomized traffic against the scoreboard.
        arReadyMode = 2;
        base = hsTotal;
        pushed = 0;
        for (int c = 0; c < 400; c++) begin
            tick();
            if ($urandom_range(0, 2) == 0 && pushed < 60) begin
                applyStimulus(int'($urandom_range(0, 15)), AW'($urandom));
                pushed++;
            end
        end
        arReadyMode = 0;
        m_axi_arready = 1'b1;
        waitDrain("random drain");
        checkOutput("random AR count", hsTotal - base, pushed);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
